utm_prog_core: RTL
==================

UTM_PROG_CORE -- requirements
Module: utm_prog_core

Interface
REQ-001 Parameter STATE_BITS, default 3, width of the state encoding.
REQ-002 Parameter SYM_BITS, default 3, width of a tape symbol.
REQ-003 Parameter START_STATE, default 0, state loaded on start.
REQ-004 Parameter HALT_STATE, default all-ones, state that terminates a run.
REQ-005 Ports (name, direction, width, meaning):
- clock  in  1  single clock; all logic on its rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- prog_we  in  1  table write strobe.
- prog_addr  in  STATE_BITS+SYM_BITS  table index {state,sym}.
- prog_data  in  STATE_BITS+SYM_BITS+1  entry {next_state,new_sym,direction}.
- start  in  1  begin a run.
- sym_in  in  SYM_BITS  symbol under head.
- sym_in_valid  in  1  sym_in qualifier.
- sym_in_ready  out  1  core accepts a symbol.
- new_sym  out  SYM_BITS  symbol to write.
- direction  out  1  head move, 1 = right, 0 = left.
- state_out  out  STATE_BITS  next state of the current step.
- out_valid  out  1  new_sym/direction/state_out qualifier.
- out_ready  in  1  tape controller accepts the step.
- halted  out  1  run has ended.
- step_count  out  16  completed steps in the current run.

Function
REQ-006 Transition table SHALL be 2^(STATE_BITS+SYM_BITS) entries, registered read, one-cycle read latency, contents not cleared by reset.
REQ-007 FSM states SHALL be IDLE, WAIT_SYM, LOOKUP, OUTPUT, HALT.
REQ-008 prog_we SHALL write prog_data to prog_addr only in IDLE or HALT; writes in other states SHALL be ignored.
REQ-009 IDLE/HALT + start: state register <= START_STATE, step_count <= 0, halted <= 0, go WAIT_SYM; a simultaneous prog_we SHALL also complete and be visible to the first lookup.
REQ-010 WAIT_SYM: sym_in_ready = 1; sym_in_valid latches sym_in, issues read at {state,sym}, goes LOOKUP; sym_in_ready = 0 in all other states.
REQ-011 LOOKUP SHALL last exactly one cycle, then OUTPUT; out_valid asserts two cycles after the accepting sym_in_valid edge.
REQ-012 OUTPUT: out_valid = 1; new_sym, direction and state_out SHALL hold stable while out_ready = 0.
REQ-013 OUTPUT + out_ready: state <= next_state, step_count increments (saturating at 16'hFFFF), out_valid drops next cycle; go HALT if next_state == HALT_STATE, else WAIT_SYM.
REQ-014 HALT: halted = 1, sym_in ignored; start in HALT restarts per REQ-009.
REQ-015 start outside IDLE/HALT SHALL be ignored.

Reset
REQ-016 reset_n low at a rising edge: FSM to IDLE; out_valid, sym_in_ready, halted, new_sym, direction, state_out, step_count all 0; state register = START_STATE.
REQ-017 Reset mid-run SHALL abort without completing the pending step; table contents unchanged.

Configuration
REQ-018 Macro UTM_STEP_LIMIT_EN defined: 16-bit input step_limit added; when step_count reaches a nonzero step_limit after a step, FSM enters HALT and output timeout (1 bit) asserts until next start/reset; step_limit = 0 disables the limit.
REQ-019 Macro undefined: no step_limit/timeout ports; runs end only at HALT_STATE.

Verification
REQ-020 Program entry {0,0} = {1,5,R}, start, sym 0 -> out_valid 2 cycles later, new_sym=5, direction=1, state_out=1, step_count=1 after out_ready.
REQ-021 Hold out_ready=0 for 5 cycles in OUTPUT -> outputs stable, sym_in_ready=0, no state change.
REQ-022 Entry {2,3} -> next_state 7 (HALT_STATE) -> halted=1 after accept; further sym_in_valid ignored; start restarts with step_count=0.
REQ-023 prog_we during WAIT_SYM overwriting {0,0} -> lookup still returns the original entry.
REQ-024 reset_n low in LOOKUP -> next cycle all outputs 0, FSM IDLE; previously programmed entries still readable.
REQ-025 With UTM_STEP_LIMIT_EN, step_limit=3, self-loop table -> halted=1, timeout=1, step_count=3.

Source files
------------

// File: rtl/utm_prog_core.sv
// Programmable Turing-machine control core: transition table plus step sequencer.
// Optional step limit (step_limit input, timeout output) enabled by UTM_STEP_LIMIT_EN.
module utm_prog_core #(
    parameter int unsigned STATE_BITS  = 3,
    parameter int unsigned SYM_BITS    = 3,
    parameter int unsigned START_STATE = 0,
    parameter int unsigned HALT_STATE  = (1 << STATE_BITS) - 1
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           prog_we,
    input  logic [STATE_BITS+SYM_BITS-1:0] prog_addr,
    input  logic [STATE_BITS+SYM_BITS:0]   prog_data,
    input  logic                           start,
    input  logic [SYM_BITS-1:0]            sym_in,
    input  logic                           sym_in_valid,
    output logic                           sym_in_ready,
    output logic [SYM_BITS-1:0]            new_sym,
    output logic                           direction,
    output logic [STATE_BITS-1:0]          state_out,
    output logic                           out_valid,
    input  logic                           out_ready,
`ifdef UTM_STEP_LIMIT_EN
    input  logic [15:0]                    step_limit,
    output logic                           timeout,
`endif
    output logic                           halted,
    output logic [15:0]                    step_count
);

    localparam int unsigned AddrW = STATE_BITS + SYM_BITS;
    localparam int unsigned DataW = AddrW + 1;
    localparam logic [STATE_BITS-1:0] StartSt = STATE_BITS'(START_STATE);
    localparam logic [STATE_BITS-1:0] HaltSt  = STATE_BITS'(HALT_STATE);

    typedef enum logic [2:0] {StIdle, StWaitSym, StLookup, StOutput, StHalt} st_e;

    st_e                   st_q;
    logic [STATE_BITS-1:0] state_q;
    logic [DataW-1:0]      mem [2**AddrW];
    logic [DataW-1:0]      rd_q;
    logic                  sym_in_ready_q;
    logic [SYM_BITS-1:0]   new_sym_q;
    logic                  direction_q;
    logic [STATE_BITS-1:0] state_out_q;
    logic                  out_valid_q;
    logic                  halted_q;
    logic [15:0]           step_count_q;
    logic                  timeout_q;

    logic                  prog_en;
    logic                  accept;
    logic [15:0]           count_inc;
    logic                  next_halt;
    logic                  limit_hit;

    assign prog_en   = prog_we && (st_q == StIdle || st_q == StHalt);
    assign accept    = (st_q == StWaitSym) && sym_in_valid;
    assign count_inc = (step_count_q == 16'hFFFF) ? step_count_q : step_count_q + 16'd1;
    assign next_halt = (state_out_q == HaltSt);
`ifdef UTM_STEP_LIMIT_EN
    assign limit_hit = (step_limit != 16'd0) && (count_inc == step_limit);
    assign timeout   = timeout_q;
`else
    assign limit_hit = 1'b0;
`endif

    // Table is deliberately outside reset so programmed contents survive it.
    always_ff @(posedge clock) begin
        if (prog_en) begin
            mem[prog_addr] <= prog_data;
        end
        if (accept) begin
            rd_q <= mem[{state_q, sym_in}];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            st_q           <= StIdle;
            state_q        <= StartSt;
            sym_in_ready_q <= 1'b0;
            new_sym_q      <= '0;
            direction_q    <= 1'b0;
            state_out_q    <= '0;
            out_valid_q    <= 1'b0;
            halted_q       <= 1'b0;
            step_count_q   <= 16'd0;
            timeout_q      <= 1'b0;
        end else begin
            unique case (st_q)
                StIdle, StHalt: begin
                    if (start) begin
                        st_q           <= StWaitSym;
                        state_q        <= StartSt;
                        step_count_q   <= 16'd0;
                        halted_q       <= 1'b0;
                        timeout_q      <= 1'b0;
                        sym_in_ready_q <= 1'b1;
                    end
                end
                StWaitSym: begin
                    if (sym_in_valid) begin
                        sym_in_ready_q <= 1'b0;
                        st_q           <= StLookup;
                    end
                end
                StLookup: begin
                    state_out_q <= rd_q[DataW-1 -: STATE_BITS];
                    new_sym_q   <= rd_q[SYM_BITS:1];
                    direction_q <= rd_q[0];
                    out_valid_q <= 1'b1;
                    st_q        <= StOutput;
                end
                StOutput: begin
                    if (out_ready) begin
                        out_valid_q  <= 1'b0;
                        state_q      <= state_out_q;
                        step_count_q <= count_inc;
                        if (next_halt || limit_hit) begin
                            st_q      <= StHalt;
                            halted_q  <= 1'b1;
                            timeout_q <= limit_hit;
                        end else begin
                            st_q           <= StWaitSym;
                            sym_in_ready_q <= 1'b1;
                        end
                    end
                end
                default: st_q <= StIdle;
            endcase
        end
    end

    assign sym_in_ready = sym_in_ready_q;
    assign new_sym      = new_sym_q;
    assign direction    = direction_q;
    assign state_out    = state_out_q;
    assign out_valid    = out_valid_q;
    assign halted       = halted_q;
    assign step_count   = step_count_q;

endmodule
